// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode constants: state encodings, reset words, opcode fields.
// Used by fetch_stage and the decode control unit.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [15:0] NOP_WORD_DEF = 16'h0800;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [4:0]  OP_HALT      = 5'b00000;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int FN_HI  = 1;
  localparam int FN_LO  = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_plus2;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack port between fetch_stage and imem.
// master = fetch side, slave = memory side.
interface fetch_stage_if;
  logic        req;
  logic [15:0] addr;
  logic        ack;
  logic [15:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc_plus2} holding register absorbing decode stalls.
// flush wins over load, load wins over unload.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   unload,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q,
  output logic   full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      q    <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack, IF/ID register, redirect/halt.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF,
  parameter logic [15:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master imem,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [15:0]   redirect_pc,
  input  logic          halt,
  output logic [15:0]   if_instr,
  output logic [4:0]    if_instr1,
  output logic [1:0]    if_instr2,
  output logic [15:0]   if_pc_plus2,
  output logic          if_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]   perf_fetch_cnt,
  output logic [15:0]   perf_stall_cnt,
`endif
  output logic          halted
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d, pc_plus2;
  logic [15:0]  drain_q, drain_d;
  logic         hpend_q, hpend_d;
  if_id_t       ifid_q, ifid_d;
  logic         valid_q, valid_d;
  logic         req, acc;
  logic         sk_load, sk_unload, sk_flush, sk_full;
  if_id_t       sk_q;

  assign pc_plus2 = pc_q + 16'd2;

  assign req = rst_n
             & (((state_q == S_REQ) & ~sk_full)
             | (state_q == S_DRAIN));
  assign acc = req & imem.ack;

  assign imem.req  = req;
  assign imem.addr = (state_q == S_DRAIN) ? drain_q : pc_q;

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (sk_load),
    .unload (sk_unload),
    .flush  (sk_flush),
    .d      ('{instr: imem.rdata, pc_plus2: pc_plus2}),
    .q      (sk_q),
    .full   (sk_full)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drain_d   = drain_q;
    hpend_d   = hpend_q;
    ifid_d    = ifid_q;
    valid_d   = valid_q;
    sk_load   = 1'b0;
    sk_unload = 1'b0;
    sk_flush  = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          valid_d  = 1'b0;
          sk_flush = 1'b1;
          if (req && !imem.ack) begin
            state_d = S_DRAIN;
            drain_d = pc_q;
          end
        end else if (halt) begin
          valid_d  = 1'b0;
          sk_flush = 1'b1;
          if (req && !imem.ack) begin
            state_d = S_DRAIN;
            drain_d = pc_q;
            hpend_d = 1'b1;
          end else begin
            state_d = S_HALTED;
          end
        end else if (acc) begin
          pc_d = pc_plus2;
          if (valid_q && stall) begin
            sk_load = 1'b1;
          end else begin
            ifid_d  = '{instr: imem.rdata, pc_plus2: pc_plus2};
            valid_d = 1'b1;
          end
        end else if (!stall) begin
          // decode took the held word; refill from skid or go empty
          if (sk_full) begin
            ifid_d    = sk_q;
            valid_d   = 1'b1;
            sk_unload = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          valid_d  = 1'b0;
          sk_flush = 1'b1;
        end else if (halt) begin
          valid_d  = 1'b0;
          sk_flush = 1'b1;
          hpend_d  = 1'b1;
        end
        if (imem.ack) begin
          state_d = (hpend_q || (halt && !redirect_valid))
                  ? S_HALTED : S_REQ;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drain_q <= '0;
      hpend_q <= 1'b0;
      ifid_q  <= '{instr: NOP_WORD, pc_plus2: 16'h0000};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      hpend_q <= hpend_d;
      ifid_q  <= ifid_d;
      valid_q <= valid_d;
    end
  end

  assign if_valid    = valid_q;
  assign if_instr    = valid_q ? ifid_q.instr : NOP_WORD;
  assign if_instr1   = if_instr[OPC_HI:OPC_LO];
  assign if_instr2   = if_instr[FN_HI:FN_LO];
  assign if_pc_plus2 = ifid_q.pc_plus2;
  assign halted      = (state_q == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc, stall_inc;

  assign fetch_inc = (state_q == S_REQ) & acc
                   & ~redirect_valid & ~halt;
  assign stall_inc = stall & valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (state_q != S_HALTED) begin
      if (fetch_inc && perf_fetch_cnt != 16'hFFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (stall_inc && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
